// File: rtl/decode_issue_stage.sv
// decode_issue_stage: buffered decode/issue stage between fetch and the ROB/RS/LSB.
// Fetched instructions are held in a circular instruction queue. The queue head
// is decoded from inst[6:0], its operands are resolved, and at most one
// instruction per cycle leaves through the registered issue_* port.
// Optional feature macro: DC_CDB_FWD_EN enables same-cycle forwarding from the
// CDB channels. Without it the CDB ports are ignored.
module decode_issue_stage #(
   parameter int IQ_DEPTH  = 4,
   parameter int ROB_IDX_W = 4,
   parameter int CDB_N     = 2
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        rdy_in,
   input  logic                        clr_in,
   input  logic                        if_valid,
   input  logic [31:0]                 if_inst,
   input  logic [31:0]                 if_pc,
   input  logic                        if_pred_br,
   output logic                        iq_full,
   input  logic                        rob_full,
   input  logic                        rs_full,
   input  logic                        lsb_full,
   output logic [4:0]                  reg_rs1_pos,
   output logic [4:0]                  reg_rs2_pos,
   input  logic [31:0]                 reg_rs1_val,
   input  logic [31:0]                 reg_rs2_val,
   input  logic [ROB_IDX_W-1:0]        reg_rs1_dep,
   input  logic [ROB_IDX_W-1:0]        reg_rs2_dep,
   output logic [ROB_IDX_W-1:0]        rob_rs1_check,
   output logic [ROB_IDX_W-1:0]        rob_rs2_check,
   input  logic                        rob_rs1_ready,
   input  logic                        rob_rs2_ready,
   input  logic [31:0]                 rob_rs1_val,
   input  logic [31:0]                 rob_rs2_val,
   input  logic [ROB_IDX_W-1:0]        rob_rename_index,
   input  logic [CDB_N-1:0]            cdb_valid,
   input  logic [CDB_N*ROB_IDX_W-1:0]  cdb_idx,
   input  logic [CDB_N*32-1:0]         cdb_val,
   output logic                        issue_ready,
   output logic                        issue_rs_ready,
   output logic                        issue_lsb_ready,
   output logic [ROB_IDX_W-1:0]        issue_rob_index,
   output logic [5:0]                  issue_op,
   output logic [4:0]                  issue_rd,
   output logic [31:0]                 issue_rs1_val,
   output logic [31:0]                 issue_rs2_val,
   output logic [ROB_IDX_W-1:0]        issue_rs1_depend,
   output logic [ROB_IDX_W-1:0]        issue_rs2_depend,
   output logic [31:0]                 issue_imm,
   output logic [31:0]                 issue_pc,
   output logic                        issue_pred_br,
   output logic [15:0]                 illegal_cnt
);

   localparam int PTR_W = $clog2(IQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Operation encoding shared with the RS/LSB
   localparam logic [5:0] OPENUM_NOP   = 6'd0;
   localparam logic [5:0] OPENUM_LUI   = 6'd1;
   localparam logic [5:0] OPENUM_AUIPC = 6'd2;
   localparam logic [5:0] OPENUM_JAL   = 6'd3;
   localparam logic [5:0] OPENUM_JALR  = 6'd4;
   localparam logic [5:0] OPENUM_BEQ   = 6'd5;
   localparam logic [5:0] OPENUM_BNE   = 6'd6;
   localparam logic [5:0] OPENUM_BLT   = 6'd7;
   localparam logic [5:0] OPENUM_BGE   = 6'd8;
   localparam logic [5:0] OPENUM_BLTU  = 6'd9;
   localparam logic [5:0] OPENUM_BGEU  = 6'd10;
   localparam logic [5:0] OPENUM_LB    = 6'd11;
   localparam logic [5:0] OPENUM_LH    = 6'd12;
   localparam logic [5:0] OPENUM_LW    = 6'd13;
   localparam logic [5:0] OPENUM_LBU   = 6'd14;
   localparam logic [5:0] OPENUM_LHU   = 6'd15;
   localparam logic [5:0] OPENUM_SB    = 6'd16;
   localparam logic [5:0] OPENUM_SH    = 6'd17;
   localparam logic [5:0] OPENUM_SW    = 6'd18;
   localparam logic [5:0] OPENUM_ADDI  = 6'd19;
   localparam logic [5:0] OPENUM_SLTI  = 6'd20;
   localparam logic [5:0] OPENUM_SLTIU = 6'd21;
   localparam logic [5:0] OPENUM_XORI  = 6'd22;
   localparam logic [5:0] OPENUM_ORI   = 6'd23;
   localparam logic [5:0] OPENUM_ANDI  = 6'd24;
   localparam logic [5:0] OPENUM_SLLI  = 6'd25;
   localparam logic [5:0] OPENUM_SRLI  = 6'd26;
   localparam logic [5:0] OPENUM_SRAI  = 6'd27;
   localparam logic [5:0] OPENUM_ADD   = 6'd28;
   localparam logic [5:0] OPENUM_SUB   = 6'd29;
   localparam logic [5:0] OPENUM_SLL   = 6'd30;
   localparam logic [5:0] OPENUM_SLT   = 6'd31;
   localparam logic [5:0] OPENUM_SLTU  = 6'd32;
   localparam logic [5:0] OPENUM_XOR   = 6'd33;
   localparam logic [5:0] OPENUM_SRL   = 6'd34;
   localparam logic [5:0] OPENUM_SRA   = 6'd35;
   localparam logic [5:0] OPENUM_OR    = 6'd36;
   localparam logic [5:0] OPENUM_AND   = 6'd37;

   // Queue state
   logic [31:0]          iq_inst_q [IQ_DEPTH];
   logic [31:0]          iq_inst_d [IQ_DEPTH];
   logic [31:0]          iq_pc_q   [IQ_DEPTH];
   logic [31:0]          iq_pc_d   [IQ_DEPTH];
   logic                 iq_pred_q [IQ_DEPTH];
   logic                 iq_pred_d [IQ_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;

   // Issue port registers
   logic                 issue_ready_q, issue_ready_d;
   logic                 issue_rs_ready_q, issue_rs_ready_d;
   logic                 issue_lsb_ready_q, issue_lsb_ready_d;
   logic [ROB_IDX_W-1:0] issue_rob_index_q, issue_rob_index_d;
   logic [5:0]           issue_op_q, issue_op_d;
   logic [4:0]           issue_rd_q, issue_rd_d;
   logic [31:0]          issue_rs1_val_q, issue_rs1_val_d;
   logic [31:0]          issue_rs2_val_q, issue_rs2_val_d;
   logic [ROB_IDX_W-1:0] issue_rs1_dep_q, issue_rs1_dep_d;
   logic [ROB_IDX_W-1:0] issue_rs2_dep_q, issue_rs2_dep_d;
   logic [31:0]          issue_imm_q, issue_imm_d;
   logic [31:0]          issue_pc_q, issue_pc_d;
   logic                 issue_pred_q, issue_pred_d;
   logic [15:0]          illegal_cnt_q, illegal_cnt_d;

   // Head of queue and handshake terms
   logic [31:0]          head_inst_s;
   logic [31:0]          head_pc_s;
   logic                 head_pred_s;
   logic                 head_valid_s;
   logic                 stall_s;
   logic                 push_s;
   logic                 pop_s;

   // Decoder outputs
   logic [5:0]           dec_op_s;
   logic [31:0]          dec_imm_s;
   logic [4:0]           dec_rd_s;
   logic                 dec_illegal_s;
   logic                 dec_lsb_s;
   logic                 dec_no_rs1_s;
   logic                 dec_no_rs2_s;

   // Operand resolution, index 0 = rs1, index 1 = rs2
   logic [ROB_IDX_W-1:0] src_dep_s     [2];
   logic [31:0]          src_reg_val_s [2];
   logic                 src_rob_rdy_s [2];
   logic [31:0]          src_rob_val_s [2];
   logic [31:0]          opnd_val_s    [2];
   logic [ROB_IDX_W-1:0] opnd_dep_s    [2];

   assign head_inst_s  = iq_inst_q[rd_ptr_q];
   assign head_pc_s    = iq_pc_q[rd_ptr_q];
   assign head_pred_s  = iq_pred_q[rd_ptr_q];
   assign head_valid_s = (count_q != {CNT_W{1'b0}});
   assign iq_full      = (count_q == CNT_W'(IQ_DEPTH));
   assign stall_s      = rob_full | rs_full | lsb_full;
   assign push_s       = if_valid & ~iq_full & rdy_in & ~clr_in;
   assign pop_s        = head_valid_s & ~stall_s & rdy_in & ~clr_in;

   assign reg_rs1_pos   = head_inst_s[19:15];
   assign reg_rs2_pos   = head_inst_s[24:20];
   assign rob_rs1_check = reg_rs1_dep;
   assign rob_rs2_check = reg_rs2_dep;

   assign src_dep_s[0]     = reg_rs1_dep;
   assign src_dep_s[1]     = reg_rs2_dep;
   assign src_reg_val_s[0] = reg_rs1_val;
   assign src_reg_val_s[1] = reg_rs2_val;
   assign src_rob_rdy_s[0] = rob_rs1_ready;
   assign src_rob_rdy_s[1] = rob_rs2_ready;
   assign src_rob_val_s[0] = rob_rs1_val;
   assign src_rob_val_s[1] = rob_rs2_val;

`ifndef DC_CDB_FWD_EN
   // CDB broadcasts are intentionally ignored in this build
   logic unused_cdb_s;
   assign unused_cdb_s = ^{cdb_valid, cdb_idx, cdb_val};
`endif

   // Decode the queue head: operation, immediate, destination, target unit, legality
   always_comb begin
      dec_op_s      = OPENUM_NOP;
      dec_imm_s     = 32'h0;
      dec_rd_s      = head_inst_s[11:7];
      dec_illegal_s = 1'b0;
      dec_lsb_s     = 1'b0;
      dec_no_rs1_s  = 1'b0;
      dec_no_rs2_s  = 1'b0;
      case (head_inst_s[6:0])
         7'b0110111: begin
            dec_op_s = OPENUM_LUI;   dec_imm_s = {head_inst_s[31:12], 12'h0};
            dec_no_rs1_s = 1'b1;     dec_no_rs2_s = 1'b1;
         end
         7'b0010111: begin
            dec_op_s = OPENUM_AUIPC; dec_imm_s = {head_inst_s[31:12], 12'h0};
            dec_no_rs1_s = 1'b1;     dec_no_rs2_s = 1'b1;
         end
         7'b1101111: begin
            dec_op_s  = OPENUM_JAL;
            dec_imm_s = {{11{head_inst_s[31]}}, head_inst_s[31], head_inst_s[19:12],
                         head_inst_s[20], head_inst_s[30:21], 1'b0};
            dec_no_rs1_s = 1'b1;     dec_no_rs2_s = 1'b1;
         end
         7'b1100111: begin
            dec_op_s      = OPENUM_JALR;
            dec_imm_s     = {{20{head_inst_s[31]}}, head_inst_s[31:20]};
            dec_no_rs2_s  = 1'b1;
            dec_illegal_s = (head_inst_s[14:12] != 3'b000);
         end
         7'b1100011: begin
            dec_rd_s  = 5'd0;
            dec_imm_s = {{19{head_inst_s[31]}}, head_inst_s[31], head_inst_s[7],
                         head_inst_s[30:25], head_inst_s[11:8], 1'b0};
            case (head_inst_s[14:12])
               3'b000:  dec_op_s = OPENUM_BEQ;
               3'b001:  dec_op_s = OPENUM_BNE;
               3'b100:  dec_op_s = OPENUM_BLT;
               3'b101:  dec_op_s = OPENUM_BGE;
               3'b110:  dec_op_s = OPENUM_BLTU;
               3'b111:  dec_op_s = OPENUM_BGEU;
               default: dec_illegal_s = 1'b1;
            endcase
         end
         7'b0000011: begin
            dec_lsb_s = 1'b1;
            dec_imm_s = {{20{head_inst_s[31]}}, head_inst_s[31:20]};
            case (head_inst_s[14:12])
               3'b000:  dec_op_s = OPENUM_LB;
               3'b001:  dec_op_s = OPENUM_LH;
               3'b010:  dec_op_s = OPENUM_LW;
               3'b100:  dec_op_s = OPENUM_LBU;
               3'b101:  dec_op_s = OPENUM_LHU;
               default: dec_illegal_s = 1'b1;
            endcase
         end
         7'b0100011: begin
            dec_lsb_s = 1'b1;
            dec_rd_s  = 5'd0;
            dec_imm_s = {{20{head_inst_s[31]}}, head_inst_s[31:25], head_inst_s[11:7]};
            case (head_inst_s[14:12])
               3'b000:  dec_op_s = OPENUM_SB;
               3'b001:  dec_op_s = OPENUM_SH;
               3'b010:  dec_op_s = OPENUM_SW;
               default: dec_illegal_s = 1'b1;
            endcase
         end
         7'b0010011: begin
            dec_imm_s = {{20{head_inst_s[31]}}, head_inst_s[31:20]};
            case (head_inst_s[14:12])
               3'b000:  dec_op_s = OPENUM_ADDI;
               3'b010:  dec_op_s = OPENUM_SLTI;
               3'b011:  dec_op_s = OPENUM_SLTIU;
               3'b100:  dec_op_s = OPENUM_XORI;
               3'b110:  dec_op_s = OPENUM_ORI;
               3'b111:  dec_op_s = OPENUM_ANDI;
               3'b001: begin
                  dec_op_s      = OPENUM_SLLI;
                  dec_illegal_s = (head_inst_s[31:25] != 7'b0000000);
               end
               3'b101: begin
                  if (head_inst_s[31:25] == 7'b0000000) begin
                     dec_op_s = OPENUM_SRLI;
                  end else if (head_inst_s[31:25] == 7'b0100000) begin
                     dec_op_s = OPENUM_SRAI;
                  end else begin
                     dec_illegal_s = 1'b1;
                  end
               end
               default: dec_illegal_s = 1'b1;
            endcase
         end
         7'b0110011: begin
            case ({head_inst_s[31:25], head_inst_s[14:12]})
               10'b0000000_000: dec_op_s = OPENUM_ADD;
               10'b0100000_000: dec_op_s = OPENUM_SUB;
               10'b0000000_001: dec_op_s = OPENUM_SLL;
               10'b0000000_010: dec_op_s = OPENUM_SLT;
               10'b0000000_011: dec_op_s = OPENUM_SLTU;
               10'b0000000_100: dec_op_s = OPENUM_XOR;
               10'b0000000_101: dec_op_s = OPENUM_SRL;
               10'b0100000_101: dec_op_s = OPENUM_SRA;
               10'b0000000_110: dec_op_s = OPENUM_OR;
               10'b0000000_111: dec_op_s = OPENUM_AND;
               default:         dec_illegal_s = 1'b1;
            endcase
         end
         default: dec_illegal_s = 1'b1;
      endcase
   end

   // Resolve each source: register file, then ROB, then (optionally) lowest CDB channel
   always_comb begin
      logic hit_v;
      for (int s = 0; s < 2; s++) begin
         opnd_val_s[s] = 32'h0;
         opnd_dep_s[s] = src_dep_s[s];
         hit_v         = 1'b0;
         if (src_dep_s[s] == {ROB_IDX_W{1'b0}}) begin
            opnd_val_s[s] = src_reg_val_s[s];
         end else if (src_rob_rdy_s[s]) begin
            opnd_val_s[s] = src_rob_val_s[s];
            opnd_dep_s[s] = {ROB_IDX_W{1'b0}};
         end else begin
`ifdef DC_CDB_FWD_EN
            for (int k = 0; k < CDB_N; k++) begin
               if (!hit_v && cdb_valid[k] &&
                   (cdb_idx[k*ROB_IDX_W +: ROB_IDX_W] == src_dep_s[s])) begin
                  hit_v         = 1'b1;
                  opnd_val_s[s] = cdb_val[k*32 +: 32];
                  opnd_dep_s[s] = {ROB_IDX_W{1'b0}};
               end else begin
                  hit_v = hit_v;
               end
            end
`else
            opnd_val_s[s] = 32'h0;
`endif
         end
      end
   end

   // Next-state for queue pointers/storage, issue registers and illegal counter
   always_comb begin
      iq_inst_d         = iq_inst_q;
      iq_pc_d           = iq_pc_q;
      iq_pred_d         = iq_pred_q;
      wr_ptr_d          = wr_ptr_q;
      rd_ptr_d          = rd_ptr_q;
      count_d           = count_q;
      issue_ready_d     = issue_ready_q;
      issue_rs_ready_d  = issue_rs_ready_q;
      issue_lsb_ready_d = issue_lsb_ready_q;
      issue_rob_index_d = issue_rob_index_q;
      issue_op_d        = issue_op_q;
      issue_rd_d        = issue_rd_q;
      issue_rs1_val_d   = issue_rs1_val_q;
      issue_rs2_val_d   = issue_rs2_val_q;
      issue_rs1_dep_d   = issue_rs1_dep_q;
      issue_rs2_dep_d   = issue_rs2_dep_q;
      issue_imm_d       = issue_imm_q;
      issue_pc_d        = issue_pc_q;
      issue_pred_d      = issue_pred_q;
      illegal_cnt_d     = illegal_cnt_q;
      if (!rdy_in) begin
         issue_ready_d = issue_ready_q;
      end else if (clr_in) begin
         wr_ptr_d          = {PTR_W{1'b0}};
         rd_ptr_d          = {PTR_W{1'b0}};
         count_d           = {CNT_W{1'b0}};
         issue_ready_d     = 1'b0;
         issue_rs_ready_d  = 1'b0;
         issue_lsb_ready_d = 1'b0;
      end else begin
         issue_ready_d     = 1'b0;
         issue_rs_ready_d  = 1'b0;
         issue_lsb_ready_d = 1'b0;
         if (push_s) begin
            iq_inst_d[wr_ptr_q] = if_inst;
            iq_pc_d[wr_ptr_q]   = if_pc;
            iq_pred_d[wr_ptr_q] = if_pred_br;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_W'(1);
         end else begin
            count_d = count_q;
         end
         if (pop_s && dec_illegal_s) begin
            if (illegal_cnt_q != 16'hFFFF) begin
               illegal_cnt_d = illegal_cnt_q + 16'd1;
            end else begin
               illegal_cnt_d = illegal_cnt_q;
            end
         end else if (pop_s) begin
            issue_ready_d     = 1'b1;
            issue_rs_ready_d  = ~dec_lsb_s;
            issue_lsb_ready_d = dec_lsb_s;
            issue_rob_index_d = rob_rename_index;
            issue_op_d        = dec_op_s;
            issue_rd_d        = dec_rd_s;
            issue_imm_d       = dec_imm_s;
            issue_pc_d        = head_pc_s;
            issue_pred_d      = head_pred_s;
            if (dec_no_rs1_s) begin
               issue_rs1_val_d = 32'h0;
               issue_rs1_dep_d = {ROB_IDX_W{1'b0}};
            end else begin
               issue_rs1_val_d = opnd_val_s[0];
               issue_rs1_dep_d = opnd_dep_s[0];
            end
            if (dec_no_rs2_s) begin
               issue_rs2_val_d = 32'h0;
               issue_rs2_dep_d = {ROB_IDX_W{1'b0}};
            end else begin
               issue_rs2_val_d = opnd_val_s[1];
               issue_rs2_dep_d = opnd_dep_s[1];
            end
         end else begin
            illegal_cnt_d = illegal_cnt_q;
         end
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         iq_inst_q         <= '{default: 32'h0};
         iq_pc_q           <= '{default: 32'h0};
         iq_pred_q         <= '{default: 1'b0};
         wr_ptr_q          <= {PTR_W{1'b0}};
         rd_ptr_q          <= {PTR_W{1'b0}};
         count_q           <= {CNT_W{1'b0}};
         issue_ready_q     <= 1'b0;
         issue_rs_ready_q  <= 1'b0;
         issue_lsb_ready_q <= 1'b0;
         issue_rob_index_q <= {ROB_IDX_W{1'b0}};
         issue_op_q        <= 6'd0;
         issue_rd_q        <= 5'd0;
         issue_rs1_val_q   <= 32'h0;
         issue_rs2_val_q   <= 32'h0;
         issue_rs1_dep_q   <= {ROB_IDX_W{1'b0}};
         issue_rs2_dep_q   <= {ROB_IDX_W{1'b0}};
         issue_imm_q       <= 32'h0;
         issue_pc_q        <= 32'h0;
         issue_pred_q      <= 1'b0;
         illegal_cnt_q     <= 16'h0;
      end else begin
         iq_inst_q         <= iq_inst_d;
         iq_pc_q           <= iq_pc_d;
         iq_pred_q         <= iq_pred_d;
         wr_ptr_q          <= wr_ptr_d;
         rd_ptr_q          <= rd_ptr_d;
         count_q           <= count_d;
         issue_ready_q     <= issue_ready_d;
         issue_rs_ready_q  <= issue_rs_ready_d;
         issue_lsb_ready_q <= issue_lsb_ready_d;
         issue_rob_index_q <= issue_rob_index_d;
         issue_op_q        <= issue_op_d;
         issue_rd_q        <= issue_rd_d;
         issue_rs1_val_q   <= issue_rs1_val_d;
         issue_rs2_val_q   <= issue_rs2_val_d;
         issue_rs1_dep_q   <= issue_rs1_dep_d;
         issue_rs2_dep_q   <= issue_rs2_dep_d;
         issue_imm_q       <= issue_imm_d;
         issue_pc_q        <= issue_pc_d;
         issue_pred_q      <= issue_pred_d;
         illegal_cnt_q     <= illegal_cnt_d;
      end
   end

   assign issue_ready      = issue_ready_q;
   assign issue_rs_ready   = issue_rs_ready_q;
   assign issue_lsb_ready  = issue_lsb_ready_q;
   assign issue_rob_index  = issue_rob_index_q;
   assign issue_op         = issue_op_q;
   assign issue_rd         = issue_rd_q;
   assign issue_rs1_val    = issue_rs1_val_q;
   assign issue_rs2_val    = issue_rs2_val_q;
   assign issue_rs1_depend = issue_rs1_dep_q;
   assign issue_rs2_depend = issue_rs2_dep_q;
   assign issue_imm        = issue_imm_q;
   assign issue_pc         = issue_pc_q;
   assign issue_pred_br    = issue_pred_q;
   assign illegal_cnt      = illegal_cnt_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed testbench for decode_issue_stage (default parameters).
// Expected values are hand-computed from the RISC-V encodings below.
module tb_decode_issue_stage;

   localparam logic [5:0] OP_LUI  = 6'd1;
   localparam logic [5:0] OP_BEQ  = 6'd5;
   localparam logic [5:0] OP_SW   = 6'd18;
   localparam logic [5:0] OP_ADDI = 6'd19;
   localparam logic [5:0] OP_ADD  = 6'd28;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clr_in;
   logic        if_valid, if_pred_br;
   logic [31:0] if_inst, if_pc;
   logic        iq_full;
   logic        rob_full, rs_full, lsb_full;
   logic [4:0]  reg_rs1_pos, reg_rs2_pos;
   logic [31:0] reg_rs1_val, reg_rs2_val;
   logic [3:0]  reg_rs1_dep, reg_rs2_dep;
   logic [3:0]  rob_rs1_check, rob_rs2_check;
   logic        rob_rs1_ready, rob_rs2_ready;
   logic [31:0] rob_rs1_val, rob_rs2_val;
   logic [3:0]  rob_rename_index;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_idx;
   logic [63:0] cdb_val;
   logic        issue_ready, issue_rs_ready, issue_lsb_ready;
   logic [3:0]  issue_rob_index;
   logic [5:0]  issue_op;
   logic [4:0]  issue_rd;
   logic [31:0] issue_rs1_val, issue_rs2_val;
   logic [3:0]  issue_rs1_depend, issue_rs2_depend;
   logic [31:0] issue_imm, issue_pc;
   logic        issue_pred_br;
   logic [15:0] illegal_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   decode_issue_stage dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pred_br(if_pred_br),
      .iq_full(iq_full), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
      .reg_rs1_pos(reg_rs1_pos), .reg_rs2_pos(reg_rs2_pos),
      .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
      .reg_rs1_dep(reg_rs1_dep), .reg_rs2_dep(reg_rs2_dep),
      .rob_rs1_check(rob_rs1_check), .rob_rs2_check(rob_rs2_check),
      .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
      .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val),
      .rob_rename_index(rob_rename_index),
      .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_val(cdb_val),
      .issue_ready(issue_ready), .issue_rs_ready(issue_rs_ready),
      .issue_lsb_ready(issue_lsb_ready), .issue_rob_index(issue_rob_index),
      .issue_op(issue_op), .issue_rd(issue_rd),
      .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
      .issue_rs1_depend(issue_rs1_depend), .issue_rs2_depend(issue_rs2_depend),
      .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_pred_br(issue_pred_br),
      .illegal_cnt(illegal_cnt)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_push(input logic [31:0] inst, input logic [31:0] pc);
      if_valid = 1'b1;
      if_inst  = inst;
      if_pc    = pc;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0;
      if_valid = 1'b0; if_inst = 32'h0; if_pc = 32'h0; if_pred_br = 1'b0;
      rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
      reg_rs1_val = 32'h0; reg_rs2_val = 32'h0; reg_rs1_dep = 4'd0; reg_rs2_dep = 4'd0;
      rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0; rob_rs1_val = 32'h0; rob_rs2_val = 32'h0;
      rob_rename_index = 4'd7;
      cdb_valid = 2'b00; cdb_idx = 8'h00; cdb_val = 64'h0;

      // Reset state
      tick(); tick();
      check("rst_ready", issue_ready, 32'd0);
      check("rst_iq_full", iq_full, 32'd0);
      check("rst_illegal_cnt", illegal_cnt, 32'd0);
      check("rst_op", issue_op, 32'd0);
      check("rst_imm", issue_imm, 32'd0);
      rst_in = 1'b0;

      // Independent ALU op: addi x1,x0,5
      set_push(32'h00500093, 32'h0000_0100);
      if_pred_br = 1'b1;
      tick();
      if_valid = 1'b0; if_pred_br = 1'b0;
      check("addi_rs1_pos", reg_rs1_pos, 32'd0);
      check("addi_rs2_pos", reg_rs2_pos, 32'd5);
      check("addi_not_yet", issue_ready, 32'd0);
      tick();
      check("addi_ready", issue_ready, 32'd1);
      check("addi_rs_ready", issue_rs_ready, 32'd1);
      check("addi_lsb_ready", issue_lsb_ready, 32'd0);
      check("addi_op", issue_op, 32'(OP_ADDI));
      check("addi_imm", issue_imm, 32'd5);
      check("addi_rd", issue_rd, 32'd1);
      check("addi_rs1_val", issue_rs1_val, 32'd0);
      check("addi_rs1_dep", issue_rs1_depend, 32'd0);
      check("addi_pc", issue_pc, 32'h100);
      check("addi_pred", issue_pred_br, 32'd1);
      check("addi_rob_idx", issue_rob_index, 32'd7);

      // rdy_in low holds the outputs, then strobe drops
      rdy_in = 1'b0;
      tick();
      check("rdy_hold_ready", issue_ready, 32'd1);
      rdy_in = 1'b1;
      tick();
      check("pulse_end", issue_ready, 32'd0);

      // Full and flush
      rs_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_push(32'h00500093, 32'h200 + 32'(4 * i));
         tick();
      end
      check("full_flag", iq_full, 32'd1);
      set_push(32'h00500093, 32'h210);
      tick();
      check("full_refused", iq_full, 32'd1);
      check("full_no_strobe", issue_ready, 32'd0);
      clr_in = 1'b1;
      set_push(32'h00500093, 32'h214);
      tick();
      clr_in = 1'b0; if_valid = 1'b0; rs_full = 1'b0;
      check("clr_iq_full", iq_full, 32'd0);
      check("clr_no_strobe", issue_ready, 32'd0);
      tick();
      check("clr_after1", issue_ready, 32'd0);
      tick();
      check("clr_after2", issue_ready, 32'd0);

      // Forwarding: add x3,x1,x2 with rs1 waiting on tag 3 (CDB channel 1)
      reg_rs1_dep = 4'd3; reg_rs2_dep = 4'd5;
      cdb_valid = 2'b10; cdb_idx = {4'd3, 4'd5}; cdb_val = {32'hDEAD, 32'h1111};
      set_push(32'h002081B3, 32'h300);
      tick();
      if_valid = 1'b0;
      check("rob_check", rob_rs1_check, 32'd3);
      tick();
      check("fwd_op", issue_op, 32'(OP_ADD));
      check("fwd_rd", issue_rd, 32'd3);
`ifdef DC_CDB_FWD_EN
      check("fwd_rs1_val", issue_rs1_val, 32'hDEAD);
      check("fwd_rs1_dep", issue_rs1_depend, 32'd0);
`else
      check("fwd_rs1_val", issue_rs1_val, 32'h0);
      check("fwd_rs1_dep", issue_rs1_depend, 32'd3);
`endif
      check("fwd_rs2_val", issue_rs2_val, 32'h0);
      check("fwd_rs2_dep", issue_rs2_depend, 32'd5);

      // Two matching channels: the lowest-numbered one wins
      cdb_valid = 2'b11; cdb_idx = {4'd3, 4'd3};
      reg_rs2_dep = 4'd0; reg_rs2_val = 32'h22;
      set_push(32'h002081B3, 32'h304);
      tick();
      if_valid = 1'b0;
      tick();
`ifdef DC_CDB_FWD_EN
      check("fwd_low_ch", issue_rs1_val, 32'h1111);
      check("fwd_low_dep", issue_rs1_depend, 32'd0);
`else
      check("fwd_low_ch", issue_rs1_val, 32'h0);
      check("fwd_low_dep", issue_rs1_depend, 32'd3);
`endif
      check("reg_rs2_val", issue_rs2_val, 32'h22);

      // ROB ready has priority over the CDB
      rob_rs1_ready = 1'b1; rob_rs1_val = 32'hBEEF;
      set_push(32'h002081B3, 32'h308);
      tick();
      if_valid = 1'b0;
      tick();
      check("rob_val", issue_rs1_val, 32'hBEEF);
      check("rob_dep", issue_rs1_depend, 32'd0);
      rob_rs1_ready = 1'b0; cdb_valid = 2'b00;

      // LUI forces operands: lui x5,0x12345
      reg_rs1_dep = 4'd0; reg_rs1_val = 32'h55; reg_rs2_dep = 4'd3;
      set_push(32'h123452B7, 32'h30C);
      tick();
      if_valid = 1'b0;
      tick();
      check("lui_op", issue_op, 32'(OP_LUI));
      check("lui_imm", issue_imm, 32'h12345000);
      check("lui_rd", issue_rd, 32'd5);
      check("lui_rs1_val", issue_rs1_val, 32'h0);
      check("lui_rs2_dep", issue_rs2_depend, 32'd0);
      reg_rs1_val = 32'h0; reg_rs2_dep = 4'd0; reg_rs2_val = 32'h0;

      // Store held by LSB stall, then issued: sw x2,-4(x1)
      lsb_full = 1'b1;
      set_push(32'hFE20AE23, 32'h400);
      tick();
      if_valid = 1'b0;
      tick();
      check("sw_stall1", issue_ready, 32'd0);
      tick();
      check("sw_stall2", issue_ready, 32'd0);
      lsb_full = 1'b0;
      tick();
      check("sw_ready", issue_ready, 32'd1);
      check("sw_lsb", issue_lsb_ready, 32'd1);
      check("sw_rs", issue_rs_ready, 32'd0);
      check("sw_op", issue_op, 32'(OP_SW));
      check("sw_imm", issue_imm, 32'hFFFFFFFC);
      check("sw_rd", issue_rd, 32'd0);

      // Branch: beq x1,x2,-8
      set_push(32'hFE208CE3, 32'h404);
      tick();
      if_valid = 1'b0;
      tick();
      check("beq_rs", issue_rs_ready, 32'd1);
      check("beq_lsb", issue_lsb_ready, 32'd0);
      check("beq_op", issue_op, 32'(OP_BEQ));
      check("beq_imm", issue_imm, 32'hFFFFFFF8);
      check("beq_rd", issue_rd, 32'd0);

      // Illegal instruction followed by a valid one
      set_push(32'hFFFFFFFF, 32'h500);
      tick();
      set_push(32'h00500093, 32'h504);
      tick();
      if_valid = 1'b0;
      check("ill_no_strobe", issue_ready, 32'd0);
      check("ill_cnt", illegal_cnt, 32'd1);
      tick();
      check("ill_next_ready", issue_ready, 32'd1);
      check("ill_next_pc", issue_pc, 32'h504);

      // Wrap-around: 3*IQ_DEPTH back-to-back pushes issue in order
      for (int i = 0; i <= 12; i++) begin
         if (i < 12) begin
            set_push(32'h00000093 | (32'(i) << 20), 32'h1000 + 32'(4 * i));
         end else begin
            if_valid = 1'b0;
         end
         tick();
         if (i >= 1) begin
            check("wrap_ready", issue_ready, 32'd1);
            check("wrap_pc", issue_pc, 32'h1000 + 32'(4 * (i - 1)));
            check("wrap_imm", issue_imm, 32'(i - 1));
         end else begin
            check("wrap_first", issue_ready, 32'd0);
         end
      end
      tick();
      check("wrap_done", issue_ready, 32'd0);
      check("wrap_empty", iq_full, 32'd0);
      check("final_ill_cnt", illegal_cnt, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Buffered, parametrised decode/issue stage between instruction fetch and the ROB/RS/LSB. Fetched instructions enter an internal instruction queue, and opcodes are decoded from `inst[6:0]` rather than supplied by fetch. Operands are resolved from the register file, the ROB and N common-data-bus channels, and at most one instruction per cycle is issued through a registered issue port. This decouples fetch from back-end stalls and removes the combinational fetch-to-issue path.

## Interface
Parameters:
- `IQ_DEPTH`, 4: instruction queue entries; power of two, ≥2.
- `ROB_IDX_W`, 4: ROB index width; index 0 means "no dependency".
- `CDB_N`, 2: number of result broadcast channels.

Ports:
- `clk_in` in 1: clock. One clock domain.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: global enable; when low, all state holds.
- `clr_in` in 1: mispredict flush.
- `if_valid` in 1, `if_inst` in 32, `if_pc` in 32, `if_pred_br` in 1: fetch push.
- `iq_full` out 1: queue cannot accept a push this cycle.
- `rob_full`, `rs_full`, `lsb_full` in 1 each: back-end stall inputs.
- `reg_rs1_pos`, `reg_rs2_pos` out 5: register file read addresses, taken from the queue head.
- `reg_rs1_val`, `reg_rs2_val` in 32; `reg_rs1_dep`, `reg_rs2_dep` in ROB_IDX_W: register file read data and rename tags.
- `rob_rs1_check`, `rob_rs2_check` out ROB_IDX_W: equal to `reg_rs*_dep`.
- `rob_rs1_ready`, `rob_rs2_ready` in 1; `rob_rs1_val`, `rob_rs2_val` in 32: ROB operand lookup.
- `rob_rename_index` in ROB_IDX_W: ROB entry to allocate.
- `cdb_valid` in CDB_N; `cdb_idx` in CDB_N*ROB_IDX_W; `cdb_val` in CDB_N*32: result broadcasts. Channel k occupies slice k.
- `issue_ready`, `issue_rs_ready`, `issue_lsb_ready` out 1: issue strobes.
- `issue_rob_index` out ROB_IDX_W; `issue_op` out 6 (`OPENUM_*` from def.v); `issue_rd` out 5.
- `issue_rs1_val`, `issue_rs2_val` out 32; `issue_rs1_depend`, `issue_rs2_depend` out ROB_IDX_W.
- `issue_imm` out 32, `issue_pc` out 32, `issue_pred_br` out 1.
- `illegal_cnt` out 16: count of dropped illegal instructions.

## Operation
- **Queue.** Circular buffer with `log2(IQ_DEPTH)` read and write pointers that wrap modulo depth, plus an occupancy count.
  - `iq_full` = (count == IQ_DEPTH), derived from the registered count.
  - A push when full is refused, even if a pop happens in the same cycle.
- **Push.** On an edge with `if_valid && !iq_full && rdy_in && !clr_in`, write {inst, pc, pred_br} at the write pointer.
- **Pop/issue.** On an edge with head valid, `!(rob_full||rs_full||lsb_full)`, `rdy_in`, `!clr_in`:
  - dequeue the head;
  - register the decoded fields into `issue_*`;
  - set `issue_ready` = 1 and exactly one of `issue_rs_ready` / `issue_lsb_ready`.
  - Otherwise all three strobes are 0 on the next cycle.
- **Operand priority, per source:**
  1. dep == 0 → register value;
  2. ROB ready → ROB value;
  3. lowest-numbered CDB channel with valid && idx == dep → `cdb_val`;
  4. else value 0, depend = dep.
- **Classes:**
  - LUI/AUIPC/JAL: both operands and depends forced to 0.
  - JALR: rs2 forced to 0.
  - BR and ST: `issue_rd` = 0.
  - LD and ST go to the LSB; all other classes go to the RS.
- **Immediates:** I, S, B, U and J formats, sign-extended to 32 bits; B and J have bit 0 = 0.
- **Illegal instructions:** undefined opcode, or func3/func7 combination. The head is dequeued with no strobe, `illegal_cnt` increments and saturates at 0xFFFF, and the pop consumes the issue slot for that cycle.
- **Flush:** `clr_in` empties the queue (pointers and count to 0) and clears the strobes on the same edge. clr has priority over a simultaneous push or pop.
- **Reset:** all pointers, the count, every `issue_*` output and `illegal_cnt` are 0.

## Timing
- Push accepted at edge E0 → earliest `issue_ready` is high for the cycle after edge E1. Latency 1, throughput 1 per cycle.
- Strobes are single-cycle pulses unless consecutive issues occur.
- Stall is sampled combinationally at the issue edge; the head remains queued until it is accepted.
- A simultaneous push and pop with count < IQ_DEPTH leaves the count unchanged.
- `rdy_in` low: the queue, the outputs and `illegal_cnt` all hold. Downstream consumers also gate on `rdy_in`.
- Reset or clear during a stall: the queue is emptied and nothing is issued afterward.
- Forwarding covers broadcasts in the issue cycle only. Broadcasts in later cycles are the RS/LSB's responsibility.

## Configuration
- `DC_CDB_FWD_EN` defined: CDB forwarding (operand priority step 3) is active.
- Not defined: step 3 is removed. The CDB ports remain but are ignored, and unresolved operands carry their dependency tag.

## Test plan
- **Independent ALU op.** Reset; push `addi x1,x0,5` (0x00500093), deps 0 → next cycle: `issue_ready`=1, `issue_rs_ready`=1, op=ADDI, imm=5, rd=1, rs1_val=0.
- **Full and flush.** Hold `rs_full`=1 and push IQ_DEPTH instructions → `iq_full`=1, a 5th push is refused, no strobes. Assert `clr_in` → count 0, `iq_full`=0, no later issue.
- **Forwarding.** rs1 dep=3, ROB not ready, `cdb_valid`=2'b10, `cdb_idx[1]`=3, `cdb_val[1]`=0xDEAD → `issue_rs1_val`=0xDEAD, depend 0. With `DC_CDB_FWD_EN` undefined → `issue_rs1_depend`=3.
- **Store and branch.** Push `sw x2,-4(x1)` → `issue_lsb_ready`=1, imm=0xFFFFFFFC, rd=0. Push `beq` with offset -8 → imm=0xFFFFFFF8, rd=0.
- **Illegal opcode.** Push 0xFFFFFFFF → no strobe, `illegal_cnt`=1, and the following valid instruction issues on the next cycle.
- **Wrap-around.** Stream 3×IQ_DEPTH pushes with issue enabled → all issue in order, with PCs matching push order.
